// File: rtl/pe_psum_accumulator_if.sv
// Bit-plane partial-sum stream in, accumulated result out under valid/ready.
// Signal names are from the accumulator's point of view.
interface pe_psum_accumulator_if #(
  parameter int unsigned NSaCols       = 256,
  parameter int unsigned NAdderOutBits = 6,
  parameter int unsigned AccWidth      = 11
);
  logic                                    start_i;
  logic                                    psum_valid_i;
  logic [NSaCols-1:0][NAdderOutBits-1:0]   psum_i;
  logic [NSaCols-1:0][AccWidth-1:0]        acc_o;
  logic                                    acc_valid_o;
  logic                                    acc_ready_i;

  // Producer / consumer side (PE output buffer plus writeback stage)
  modport master (
    output start_i, psum_valid_i, psum_i, acc_ready_i,
    input  acc_o, acc_valid_o
  );

  // Accumulator side
  modport slave (
    input  start_i, psum_valid_i, psum_i, acc_ready_i,
    output acc_o, acc_valid_o
  );
endinterface

// File: rtl/pe_psum_accumulator.sv
// Shift-adds InputPrecision LSB-first bit-plane partial sums per column into one
// signed MAC result per lane, then holds it until the downstream stage accepts it.
module pe_psum_accumulator #(
  parameter int unsigned NSaCols        = 256,
  parameter int unsigned NAdderOutBits  = 6,
  parameter int unsigned InputPrecision = 4,
  parameter bit          InputSigned    = 1'b0,
  parameter int unsigned AccWidth       = NAdderOutBits + InputPrecision + 1
) (
  input  logic                         clk,
  input  logic                         nrst,
  pe_psum_accumulator_if.slave         bus,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned KW = (InputPrecision > 1) ? $clog2(InputPrecision) : 1;
  localparam logic [KW-1:0] LastK = KW'(InputPrecision - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                             state_q, state_d;
  logic [KW-1:0]                      k_q, k_d;
  logic [NSaCols-1:0][AccWidth-1:0]   acc_q, acc_d;
  logic                               valid_q, valid_d;
  logic                               busy_q, busy_d;
  logic                               err_q, err_d;

  logic                               beat;
  logic [KW-1:0]                      beat_k;
  logic [NSaCols-1:0][AccWidth-1:0]   beat_sum;

  // A beat is accepted in ACCUM, or in IDLE when it coincides with start (plane 0)
  assign beat   = bus.psum_valid_i &&
                  ((state_q == StIdle && bus.start_i) || state_q == StAccum);
  assign beat_k = (state_q == StIdle) ? '0 : k_q;

  // Per-lane sum of the running accumulator and this plane's weighted contribution
  always_comb begin : p_datapath
    logic [AccWidth-1:0] contrib;
    logic [AccWidth-1:0] base;
    beat_sum = '0;
    contrib  = '0;
    base     = '0;
    for (int l = 0; l < int'(NSaCols); l++) begin
      contrib = AccWidth'(bus.psum_i[l]) << beat_k;
      // A beat taken from IDLE starts a fresh accumulation
      base    = (state_q == StIdle) ? '0 : acc_q[l];
      if (InputSigned && beat_k == LastK) begin
        beat_sum[l] = base - contrib;  // MSB plane carries negative weight
      end else begin
        beat_sum[l] = base + contrib;
      end
    end
  end

  // Next-state, handshake and protocol-error decode
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          state_d = StAccum;
          k_d     = '0;
          acc_d   = '0;
        end else if (bus.psum_valid_i) begin
          err_d = 1'b1;
        end
      end
      StAccum: begin
        if (bus.start_i) err_d = 1'b1;
      end
      StHold: begin
        if (bus.psum_valid_i) err_d = 1'b1;
        if (bus.acc_ready_i) begin
          valid_d = 1'b0;
          if (bus.start_i) begin
            state_d = StAccum;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (bus.start_i) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (beat) begin
      acc_d = beat_sum;
      if (beat_k == LastK) begin
        state_d = StHold;
        valid_d = 1'b1;
        k_d     = '0;
      end else begin
        state_d = StAccum;
        k_d     = beat_k + KW'(1);
      end
    end
  end

  assign busy_d = (state_d != StIdle);

  // State and output registers; reset drops any in-flight result
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      k_q     <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.acc_o       = acc_q;
  assign bus.acc_valid_o = valid_q;
  assign busy_o          = busy_q;
  assign err_o           = err_q;

endmodule
